// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter: round-robin arbiter sharing one synchronous-FIFO write port
// among N_REQ valid/ready producers. The winner drives the FIFO port in the
// same cycle. Fairness state (last_q) only advances when a beat is written.
// Optional feature macro: ARB_BURST_EN keeps the grant on one requester for up
// to MAX_BURST consecutive beats.
module fifo_wr_arbiter #(
    parameter int unsigned N_REQ     = 4,
    parameter int unsigned WIDTH     = 32,
    parameter int unsigned MAX_BURST = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [N_REQ-1:0]           req_valid,
    input  logic [N_REQ*WIDTH-1:0]     req_data,
    output logic [N_REQ-1:0]           req_ready,
    input  logic                       fifo_full,
    output logic                       fifo_wr_en,
    output logic [WIDTH-1:0]           fifo_data_in,
    output logic                       grant_valid,
    output logic [$clog2(N_REQ)-1:0]   grant_id,
    output logic [15:0]                beat_count
);

    localparam int unsigned ID_W  = $clog2(N_REQ);
    localparam int unsigned CNT_W = 16;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    // Reject parameter sets the rotation and burst logic cannot support
    if ((N_REQ < 2) || ((N_REQ & (N_REQ - 1)) != 0) || (MAX_BURST < 1)) begin : g_bad_cfg
        $error("fifo_wr_arbiter: N_REQ must be a power of two >= 2, MAX_BURST >= 1");
    end

    logic [ID_W-1:0]  last_q, last_d;
    logic             active_q, active_d;
    logic [CNT_W-1:0] beat_count_q, beat_count_d;
    logic [ID_W-1:0]  rr_id, win_id, cand;
    logic             rr_found, xfer;

`ifdef ARB_BURST_EN
    localparam int unsigned BURST_W = $clog2(MAX_BURST + 1);
    logic               lock_q, lock_d;
    logic [ID_W-1:0]    lock_id_q, lock_id_d;
    logic [BURST_W-1:0] burst_q, burst_d, burst_cur;
    logic               lock_hit;

    // A lock only steers selection while its owner still has a beat
    assign lock_hit = lock_q && req_valid[lock_id_q];
`endif

    // Round-robin scan starting just after the last requester that transferred
    always_comb begin
        rr_id    = '0;
        rr_found = 1'b0;
        cand     = '0;
        for (int unsigned i = 1; i <= N_REQ; i++) begin
            cand = last_q + ID_W'(i);
            if (!rr_found && req_valid[cand]) begin
                rr_found = 1'b1;
                rr_id    = cand;
            end
        end
    end

    // Winner: locked burst owner if still valid, else the round-robin pick
    always_comb begin
        win_id = rr_id;
`ifdef ARB_BURST_EN
        if (lock_hit) begin
            win_id = lock_id_q;
        end
`endif
    end

    assign grant_valid = active_q && rr_found;
    assign xfer        = grant_valid && !fifo_full;
    assign fifo_wr_en  = xfer;
    assign beat_count  = beat_count_q;

    // Drive handshake and FIFO write data from the winner
    always_comb begin
        req_ready    = '0;
        fifo_data_in = '0;
        grant_id     = '0;
        if (grant_valid) begin
            grant_id          = win_id;
            fifo_data_in      = req_data[32'(win_id) * WIDTH +: WIDTH];
            req_ready[win_id] = !fifo_full;
        end
    end

    // Next-state: pointer, counter and burst lock only move on a real write
    always_comb begin
        last_d       = last_q;
        active_d     = 1'b1;
        beat_count_d = beat_count_q;
`ifdef ARB_BURST_EN
        lock_d    = lock_q;
        lock_id_d = lock_id_q;
        burst_d   = burst_q;
        burst_cur = lock_hit ? burst_q : '0;
        if (!fifo_full && lock_q && !req_valid[lock_id_q]) begin
            lock_d  = 1'b0;
            burst_d = '0;
        end
`endif
        if (xfer) begin
            last_d = win_id;
            if (beat_count_q != CNT_MAX) begin
                beat_count_d = beat_count_q + 1'b1;
            end
`ifdef ARB_BURST_EN
            if (burst_cur < BURST_W'(MAX_BURST - 1)) begin
                lock_d    = 1'b1;
                lock_id_d = win_id;
                burst_d   = burst_cur + 1'b1;
            end else begin
                lock_d  = 1'b0;
                burst_d = '0;
            end
`endif
        end
    end

    // State registers; requester 0 has first priority out of reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_q       <= ID_W'(N_REQ - 1);
            active_q     <= 1'b0;
            beat_count_q <= '0;
`ifdef ARB_BURST_EN
            lock_q       <= 1'b0;
            lock_id_q    <= '0;
            burst_q      <= '0;
`endif
        end else begin
            last_q       <= last_d;
            active_q     <= active_d;
            beat_count_q <= beat_count_d;
`ifdef ARB_BURST_EN
            lock_q       <= lock_d;
            lock_id_q    <= lock_id_d;
            burst_q      <= burst_d;
`endif
        end
    end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed bench for fifo_wr_arbiter (N_REQ=4, WIDTH=32, MAX_BURST=4).
module tb_fifo_wr_arbiter;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [3:0]   req_valid;
    logic [127:0] req_data;
    logic [3:0]   req_ready;
    logic         fifo_full;
    logic         fifo_wr_en;
    logic [31:0]  fifo_data_in;
    logic         grant_valid;
    logic [1:0]   grant_id;
    logic [15:0]  beat_count;

    int n_cmp = 0;
    int n_err = 0;

    fifo_wr_arbiter #(.N_REQ(4), .WIDTH(32), .MAX_BURST(4)) dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_data(req_data),
        .req_ready(req_ready), .fifo_full(fifo_full), .fifo_wr_en(fifo_wr_en),
        .fifo_data_in(fifo_data_in), .grant_valid(grant_valid),
        .grant_id(grant_id), .beat_count(beat_count)
    );

    always #5 clk = ~clk;

    task automatic test_reset();
        rst_n = 1'b0; req_valid = 4'hF; fifo_full = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        n_cmp++; if (grant_valid !== 1'b0) begin n_err++; $display("FAIL rst_grant_valid: got %0b expected 0", grant_valid); end
        n_cmp++; if (fifo_wr_en !== 1'b0) begin n_err++; $display("FAIL rst_wr_en: got %0b expected 0", fifo_wr_en); end
        n_cmp++; if (req_ready !== 4'h0) begin n_err++; $display("FAIL rst_req_ready: got %0h expected 0", req_ready); end
        n_cmp++; if (grant_id !== 2'd0) begin n_err++; $display("FAIL rst_grant_id: got %0d expected 0", grant_id); end
        n_cmp++; if (fifo_data_in !== 32'h0) begin n_err++; $display("FAIL rst_data: got %0h expected 0", fifo_data_in); end
        n_cmp++; if (beat_count !== 16'h0) begin n_err++; $display("FAIL rst_beat_count: got %0h expected 0", beat_count); end
        @(negedge clk); rst_n = 1'b1; #1;
        n_cmp++; if (fifo_wr_en !== 1'b0) begin n_err++; $display("FAIL idle_wr_en: got %0b expected 0", fifo_wr_en); end
        n_cmp++; if (req_ready !== 4'h0) begin n_err++; $display("FAIL idle_req_ready: got %0h expected 0", req_ready); end
    endtask

    task automatic test_round_robin();
        int exp_ids[5] = '{0, 1, 2, 3, 0};
        for (int k = 0; k < 5; k++) begin
            @(negedge clk); req_valid = 4'hF; #1;
            n_cmp++; if (grant_id !== 2'(exp_ids[k])) begin n_err++; $display("FAIL rr_grant_id[%0d]: got %0d expected %0d", k, grant_id, exp_ids[k]); end
            n_cmp++; if (fifo_wr_en !== 1'b1) begin n_err++; $display("FAIL rr_wr_en[%0d]: got %0b expected 1", k, fifo_wr_en); end
            n_cmp++; if (req_ready !== (4'b0001 << exp_ids[k])) begin n_err++; $display("FAIL rr_req_ready[%0d]: got %0h expected %0h", k, req_ready, 4'b0001 << exp_ids[k]); end
            n_cmp++; if (fifo_data_in !== 32'hC0DE_0000 + 32'(exp_ids[k])) begin n_err++; $display("FAIL rr_data[%0d]: got %0h expected %0h", k, fifo_data_in, 32'hC0DE_0000 + 32'(exp_ids[k])); end
        end
        @(negedge clk); req_valid = 4'h0; #1;
        n_cmp++; if (beat_count !== 16'd5) begin n_err++; $display("FAIL rr_beat_count: got %0d expected 5", beat_count); end
        n_cmp++; if (grant_valid !== 1'b0) begin n_err++; $display("FAIL rr_no_valid_grant: got %0b expected 0", grant_valid); end
    endtask

    task automatic test_single();
        for (int k = 0; k < 3; k++) begin
            @(negedge clk); req_valid = 4'b0100; #1;
            n_cmp++; if (grant_id !== 2'd2) begin n_err++; $display("FAIL single_grant_id[%0d]: got %0d expected 2", k, grant_id); end
            n_cmp++; if (fifo_data_in !== 32'hC0DE_0002) begin n_err++; $display("FAIL single_data[%0d]: got %0h expected c0de0002", k, fifo_data_in); end
            n_cmp++; if (fifo_wr_en !== 1'b1) begin n_err++; $display("FAIL single_wr_en[%0d]: got %0b expected 1", k, fifo_wr_en); end
        end
        @(negedge clk); req_valid = 4'h0; #1;
        n_cmp++; if (beat_count !== 16'd8) begin n_err++; $display("FAIL single_beat_count: got %0d expected 8", beat_count); end
    endtask

    task automatic test_fifo_full();
        @(negedge clk); req_valid = 4'b0001; #1;
        n_cmp++; if (grant_id !== 2'd0) begin n_err++; $display("FAIL full_setup_grant: got %0d expected 0", grant_id); end
        for (int k = 0; k < 3; k++) begin
            @(negedge clk); req_valid = 4'hF; fifo_full = 1'b1; #1;
            n_cmp++; if (grant_id !== 2'd1) begin n_err++; $display("FAIL full_grant_id[%0d]: got %0d expected 1", k, grant_id); end
            n_cmp++; if (fifo_wr_en !== 1'b0) begin n_err++; $display("FAIL full_wr_en[%0d]: got %0b expected 0", k, fifo_wr_en); end
            n_cmp++; if (req_ready !== 4'h0) begin n_err++; $display("FAIL full_req_ready[%0d]: got %0h expected 0", k, req_ready); end
            n_cmp++; if (beat_count !== 16'd9) begin n_err++; $display("FAIL full_beat_hold[%0d]: got %0d expected 9", k, beat_count); end
        end
        @(negedge clk); fifo_full = 1'b0; #1;
        n_cmp++; if (grant_id !== 2'd1) begin n_err++; $display("FAIL full_release_grant: got %0d expected 1", grant_id); end
        n_cmp++; if (req_ready !== 4'b0010) begin n_err++; $display("FAIL full_release_ready: got %0h expected 2", req_ready); end
        @(negedge clk); #1;
        n_cmp++; if (grant_id !== 2'd2) begin n_err++; $display("FAIL full_next_grant: got %0d expected 2", grant_id); end
        @(negedge clk); req_valid = 4'h0; #1;
        n_cmp++; if (beat_count !== 16'd11) begin n_err++; $display("FAIL full_beat_count: got %0d expected 11", beat_count); end
    endtask

    task automatic test_drop_valid();
        @(negedge clk); req_valid = 4'hF; #1;
        n_cmp++; if (grant_id !== 2'd3) begin n_err++; $display("FAIL drop_pre_grant: got %0d expected 3", grant_id); end
        req_valid = 4'b0111; #1;
        n_cmp++; if (grant_id !== 2'd0) begin n_err++; $display("FAIL drop_regrant: got %0d expected 0", grant_id); end
        n_cmp++; if (req_ready !== 4'b0001) begin n_err++; $display("FAIL drop_ready: got %0h expected 1", req_ready); end
        @(negedge clk); req_valid = 4'h0; #1;
        n_cmp++; if (beat_count !== 16'd12) begin n_err++; $display("FAIL drop_beat_count: got %0d expected 12", beat_count); end
    endtask

    task automatic test_saturate();
        @(negedge clk); req_valid = 4'b0001;
        repeat (65540) @(negedge clk);
        #1;
        n_cmp++; if (beat_count !== 16'hFFFF) begin n_err++; $display("FAIL sat_beat_count: got %0h expected ffff", beat_count); end
        n_cmp++; if (fifo_wr_en !== 1'b1) begin n_err++; $display("FAIL sat_wr_en: got %0b expected 1", fifo_wr_en); end
        @(negedge clk); req_valid = 4'h0; #1;
        n_cmp++; if (beat_count !== 16'hFFFF) begin n_err++; $display("FAIL sat_no_wrap: got %0h expected ffff", beat_count); end
    endtask

    task automatic test_reset_mid();
        @(negedge clk); req_valid = 4'hF; #1;
        n_cmp++; if (fifo_wr_en !== 1'b1) begin n_err++; $display("FAIL mid_pre_wr_en: got %0b expected 1", fifo_wr_en); end
        rst_n = 1'b0; #1;
        n_cmp++; if (fifo_wr_en !== 1'b0) begin n_err++; $display("FAIL mid_wr_en: got %0b expected 0", fifo_wr_en); end
        n_cmp++; if (grant_valid !== 1'b0) begin n_err++; $display("FAIL mid_grant_valid: got %0b expected 0", grant_valid); end
        n_cmp++; if (fifo_data_in !== 32'h0) begin n_err++; $display("FAIL mid_data: got %0h expected 0", fifo_data_in); end
        n_cmp++; if (beat_count !== 16'h0) begin n_err++; $display("FAIL mid_beat_count: got %0h expected 0", beat_count); end
        @(negedge clk); rst_n = 1'b1; #1;
        n_cmp++; if (fifo_wr_en !== 1'b0) begin n_err++; $display("FAIL mid_idle_wr_en: got %0b expected 0", fifo_wr_en); end
        @(negedge clk); #1;
        n_cmp++; if (grant_id !== 2'd0) begin n_err++; $display("FAIL mid_restart_grant: got %0d expected 0", grant_id); end
        n_cmp++; if (fifo_wr_en !== 1'b1) begin n_err++; $display("FAIL mid_restart_wr_en: got %0b expected 1", fifo_wr_en); end
        @(negedge clk); req_valid = 4'h0;
    endtask

`ifdef ARB_BURST_EN
    task automatic test_burst();
        int exp_ids[8] = '{0, 0, 0, 0, 1, 1, 1, 1};
        for (int k = 0; k < 8; k++) begin
            @(negedge clk); req_valid = 4'hF; #1;
            n_cmp++; if (grant_id !== 2'(exp_ids[k])) begin n_err++; $display("FAIL burst_grant_id[%0d]: got %0d expected %0d", k, grant_id, exp_ids[k]); end
        end
        test_reset();
        for (int k = 0; k < 2; k++) begin
            @(negedge clk); req_valid = 4'b0110; #1;
            n_cmp++; if (grant_id !== 2'd1) begin n_err++; $display("FAIL burst_lock_grant[%0d]: got %0d expected 1", k, grant_id); end
        end
        @(negedge clk); req_valid = 4'b0100; #1;
        n_cmp++; if (grant_id !== 2'd2) begin n_err++; $display("FAIL burst_drop_grant: got %0d expected 2", grant_id); end
        @(negedge clk); req_valid = 4'h0;
    endtask
`endif

    initial begin
        rst_n     = 1'b0;
        req_valid = 4'h0;
        fifo_full = 1'b0;
        req_data  = {32'hC0DE_0003, 32'hC0DE_0002, 32'hC0DE_0001, 32'hC0DE_0000};
        test_reset();
`ifdef ARB_BURST_EN
        test_burst();
`else
        test_round_robin();
        test_single();
        test_fifo_full();
        test_drop_valid();
        test_saturate();
        test_reset_mid();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/fifo_wr_arbiter.md
# fifo_wr_arbiter

- Round-robin write arbiter that lets N_REQ producers share the single write port of the team's synchronous FIFO (ports wr_en, data_in, full).
- Each producer uses a valid/ready handshake. The arbiter selects one winner per cycle and drives the FIFO write port combinationally from that winner.
- Fairness is tracked in registered state, so a winner only loses priority once its beat has actually been written.
- It sits between the producer blocks and the FIFO. The FIFO read side (cs, rd_en) is not touched.

## Interface
Parameters:
- N_REQ, 4, number of requesters (≥2, power of two)
- WIDTH, 32, data width; must match the FIFO WIDTH
- MAX_BURST, 4, maximum consecutive beats per grant under ARB_BURST_EN (≥1)

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst_n  in  1  reset, asynchronous, active-low
- req_valid  in  N_REQ  per-requester beat valid
- req_data  in  N_REQ*WIDTH  requester i occupies bits [i*WIDTH +: WIDTH]
- req_ready  out  N_REQ  one-hot or zero; beat i transfers when req_valid[i] && req_ready[i]
- fifo_full  in  1  FIFO full flag
- fifo_wr_en  out  1  FIFO write enable
- fifo_data_in  out  WIDTH  FIFO write data
- grant_valid  out  1  some requester is currently selected
- grant_id  out  $clog2(N_REQ)  index of the selected requester; 0 when grant_valid=0
- beat_count  out  16  total beats written since reset; saturates at 0xFFFF

## Operation
- Registered state:
  - last_q: last requester that transferred; reset N_REQ-1, so requester 0 has first priority.
  - active_q: reset 0; set to 1 on the first clock edge after reset release.
  - lock_q / lock_id_q / burst_q: burst lock state, only under ARB_BURST_EN.
  - beat_count.
- Selection (combinational):
  - If locked, the winner is lock_id_q.
  - Otherwise the winner is the first requester with req_valid set, scanning from last_q+1 upward modulo N_REQ.
  - grant_valid = active_q && (some req_valid set).
- Handshake:
  - req_ready[w] = grant_valid && !fifo_full, for the winner w only.
  - fifo_wr_en equals the transfer condition, i.e. req_ready[w] && req_valid[w].
  - fifo_data_in = req_data slice of w. When no winner, fifo_data_in = 0.
- Pointer update happens only on a transfer: last_q <= w. With no transfer (fifo_full, or no valid), last_q holds.
- A requester may drop req_valid before its transfer. Arbitration re-evaluates in the same cycle. There is no penalty.
- beat_count increments by 1 on each transfer and stops at 0xFFFF.
- Writes never happen while fifo_full=1. This guarantees the FIFO is never overrun.

## Timing
- Zero-cycle latency from request to grant: a valid beat with the FIFO not full is written at the same rising edge.
- Throughput: 1 beat/cycle aggregate while the FIFO is not full.
- While rst_n=0: all outputs are 0, last_q=N_REQ-1, beat_count=0.
- First cycle after reset release: active_q=0, so req_ready=0 and fifo_wr_en=0.
- Reset asserted mid-operation: state clears immediately and asynchronously. Any in-flight handshake is dropped; no write occurs.
- fifo_full asserted: grant_id still shows the winner, but req_ready=0, pointer and lock hold, and beat_count holds.
- Wrap-around: after requester N_REQ-1 transfers, requester 0 has the highest priority.

## Configuration
- Macro ARB_BURST_EN.
- Defined:
  - After a transfer by w, if req_valid[w] stays high and burst_q < MAX_BURST-1, lock on w and increment burst_q.
  - On the MAX_BURST-th beat, the lock clears and burst_q resets to 0, so the next requester gets priority.
  - If w drops valid while locked, the lock releases and normal round-robin resumes from w+1.
  - fifo_full freezes lock_q and burst_q.
- Not defined: no lock registers exist, and every transfer passes priority onward (MAX_BURST is effectively 1).

## Test plan
- Reset, then req_valid=4'b1111 with fifo_full=0, without burst: grant_id sequence after the idle first cycle is 0,1,2,3,0; beat_count=5 after 5 transfers.
- req_valid=4'b0100 only: requester 2 granted every cycle; fifo_data_in equals req_data[95:64]; one beat per cycle.
- All requesters valid, fifo_full=1 for 3 cycles during requester 1's grant: fifo_wr_en=0 and grant_id=1 throughout. Requester 1 transfers on the first cycle full drops, then grant moves to requester 2.
- ARB_BURST_EN, MAX_BURST=4, all valid: grant_id is 0,0,0,0,1,1,1,1,...
- ARB_BURST_EN, requester 1 drops valid after 2 beats: next grant goes to requester 2.
- beat_count preloaded by 65540 transfers: reads 0xFFFF and does not wrap.
- rst_n pulsed low mid-stream: outputs go to 0 immediately. After release, grants restart at requester 0 with one idle cycle, and beat_count=0.
